jtag_host: RTL and testbench
============================

// Module: jtag_host
// PURPOSE
// - JTAG initiator: the test-side master for the SoC's on-chip JTAG TAP/DTM.
// - Turns word-level commands (TAP reset, idle clocks, IR scan, DR scan) into TCK/TMS/TDI waveforms and samples TDO.
// - Used in simulation benches and the FPGA bring-up bridge to drive IDCODE and DMI scans at the TAP.
// - Tracks the target TAP state internally; every command starts and ends in RUN_TEST_IDLE.
// PARAMETERS
// - DIV      default 1   half-period of TCK in clk cycles minus 1; TCK = clk/(2*(DIV+1))
// - MAX_LEN  default 64  maximum scan length in bits; also the width of cmd_data and rsp_data
// PORTS
// - clk        in   1        system clock
// - rst        in   1        asynchronous, active-low reset
// - cmd_valid  in   1        command request
// - cmd_ready  out  1        host idle, can accept a command
// - cmd_op     in   2        0=RESET, 1=IDLE, 2=IR_SCAN, 3=DR_SCAN
// - cmd_len    in   LW       bit count for a scan, or TCK count for IDLE; LW=$clog2(MAX_LEN+1)
// - cmd_data   in   MAX_LEN  TDI bits, right-aligned; bit cmd_len-1 is shifted first (MSB-first)
// - rsp_valid  out  1        response available
// - rsp_ready  in   1        response consumed
// - rsp_data   out  MAX_LEN  captured TDO bits, right-aligned; first captured bit lands at bit cmd_len-1
// - rsp_err    out  1        command rejected; no TCK edges were generated for it
// - tck        out  1        JTAG clock
// - tms        out  1        JTAG mode select
// - tdi        out  1        JTAG data to target
// - tdo        in   1        JTAG data from target
// BEHAVIOUR
// - Reset values:
//   - tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
//   - Tracked TAP state = UNKNOWN.
// - Handshake and command acceptance:
//   - A command is accepted when cmd_valid && cmd_ready. cmd_op/cmd_len/cmd_data are latched at acceptance.
//   - cmd_ready deasserts on the next clk and stays low until the response handshake (rsp_valid && rsp_ready).
// - TCK phases:
//   - A "tick" is one TCK period: low phase of DIV+1 clk, then high phase of DIV+1 clk.
//   - tms/tdi change only at the start of the low phase, i.e. at the TCK falling edge.
//   - tdo is sampled on the last clk of the high phase.
// - Tick sequences (TMS value per tick):
//   - RESET: 1,1,1,1,1,0 (6 ticks). Tracked state becomes RUN_TEST_IDLE.
//   - IDLE: cmd_len ticks with TMS=0.
//   - IR_SCAN: 1,1,0,0, then cmd_len shift ticks, then 1 (update), 0 (idle) = cmd_len+6 ticks.
//   - DR_SCAN: 1,0,0, then cmd_len shift ticks, then 1, 0 = cmd_len+5 ticks.
// - Shift ticks:
//   - tdi = cmd_data[cmd_len-1-i] on shift tick i.
//   - TMS=0 on every shift tick except the last, which has TMS=1 (SHIFT->EXIT1).
//   - tdo is sampled only on shift ticks. rsp_data is shifted left with the sample entering at bit 0; upper unused bits stay 0.
//   - tdi=0 outside shift ticks.
// - Error cases (rsp_err=1, no TCK edges, rsp_data=0):
//   - cmd_len==0 for IDLE, IR_SCAN or DR_SCAN.
//   - cmd_len>MAX_LEN.
//   - IR_SCAN or DR_SCAN while the tracked state is UNKNOWN.
// - Response timing:
//   - rsp_valid rises on the clk after the final tick's high phase ends, with tck=0.
//   - For an error, rsp_valid rises 1 clk after acceptance.
//   - rsp_valid, rsp_data and rsp_err hold until rsp_ready. rsp_ready while rsp_valid=0 is ignored.
//   - A simultaneous rsp handshake and cmd_valid: cmd_ready is 0 that cycle, so the command is taken on the next cycle.
// - Internal state machine: IDLE -> PREAMBLE -> SHIFT -> POST -> RESP -> IDLE.
//   - RESET and IDLE ops skip SHIFT.
//   - Error commands go IDLE -> RESP.
// - Reset asserted mid-command:
//   - All outputs return to reset values immediately (tck=0 asynchronously).
//   - The partial response is discarded and the tracked state becomes UNKNOWN.
// - TCK idles low whenever no command is active. tms holds the last driven value (1 after reset).
// CONFIGURATION
// - JTAG_HOST_TRST_EN defined:
//   - Adds an output port trst_o (1 bit, active-low, reset value 1).
//   - A RESET op drives trst_o=0 for the first 2 ticks in addition to the TMS sequence.
// - JTAG_HOST_TRST_EN undefined:
//   - No trst_o port; reset is by the TMS sequence only. Tick counts are unchanged.
// TESTING
// - Bench uses DIV=1 (tck=clk/4) and a behavioural TAP model that follows the 16-state TAP graph.
// - RESET after rst release: 6 tck rising edges with tms 1,1,1,1,1,0 -> model in RUN_TEST_IDLE; rsp_err=0; rsp_valid held until rsp_ready.
// - DR_SCAN len=32 data=0 after IDCODE selected (model IDCODE 0x1BEEF001) -> rsp_data[31:0]=0x1BEEF001 (MSB-first); 37 ticks; model ends in RUN_TEST_IDLE.
// - IR_SCAN len=6 data=6'b101010, then DR_SCAN len=32 data=0xDEADBEEF -> model instruction=DMI; model update register=0xDEADBEEF.
// - IR_SCAN before any RESET; then DR_SCAN len=0; then len=MAX_LEN+1 -> each gives rsp_err=1, zero tck edges, rsp_valid 1 clk after acceptance.
// - Drop rst during the 10th shift tick of a 32-bit DR_SCAN -> tck=0, tms=1, rsp_valid=0 immediately; next DR_SCAN is rejected (UNKNOWN); RESET then recovers.
// - Hold rsp_ready=0 for 20 clk with cmd_valid=1 -> cmd_ready stays 0 and the second command starts only after the rsp handshake; with JTAG_HOST_TRST_EN, trst_o low exactly for ticks 0-1 of RESET.

Source files
------------

// File: rtl/jtag_host.sv
// jtag_host: word-level JTAG initiator. Turns RESET / IDLE / IR_SCAN / DR_SCAN
// commands into TCK/TMS/TDI waveforms, captures TDO, and tracks whether the
// target TAP is known to sit in RUN_TEST_IDLE. Every command starts and ends
// in RUN_TEST_IDLE.
//
// Optional feature: define JTAG_HOST_TRST_EN to add an active-low trst_o that
// is held low for the first two ticks of a RESET op.
//
// Handshakes (valid/ready): a command transfers on a clk edge where
// cmd_valid_i && cmd_ready_o; cmd_ready_o is high only while the host is idle
// and drops the clk after acceptance. A response transfers on a clk edge where
// rsp_valid_o && rsp_ready_i; rsp_valid_o, rsp_data_o and rsp_err_o are stable
// from the time rsp_valid_o rises until that edge. rsp_ready_i is ignored
// while rsp_valid_o is low, and cmd_ready_o is low in the handshake cycle, so
// a waiting command is taken one clk later.
module jtag_host #(
  parameter  int DIV     = 1,
  parameter  int MAX_LEN = 64,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [LW-1:0]      cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
`ifdef JTAG_HOST_TRST_EN
  output logic               trst_o,
`endif
  output logic [2:0]         dbg_state_o,
  output logic               dbg_tap_known_o
);

  // Tick/segment index must hold both the 6-tick preambles and len-1.
  localparam int IW = (LW > 3) ? LW : 3;
  // Phase counter counts 0..DIV inside each half of a TCK period.
  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CW-1:0] DIVC = CW'(DIV);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IDLE  = 2'd1,
    OP_IR    = 2'd2,
    OP_DR    = 2'd3
  } op_e;

  typedef enum logic {
    TAP_UNKNOWN = 1'b0,
    TAP_RTI     = 1'b1
  } tap_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               err_q, err_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  tap_e               tap_q, tap_d;

  logic               start_tick;
  logic               cmd_err;
  logic [LW-1:0]      sh_amt;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pre_last;

  // TMS value for a tick, given the segment and index the tick belongs to.
  function automatic logic tms_for(input op_e op, input state_e st,
                                   input logic [IW-1:0] idx,
                                   input logic [IW-1:0] last);
    logic t;
    t = 1'b0;
    case (st)
      ST_PRE: begin
        case (op)
          OP_RESET: t = (idx < IW'(5));
          OP_IDLE:  t = 1'b0;
          OP_IR:    t = (idx < IW'(2));
          default:  t = (idx == '0);
        endcase
      end
      ST_SHIFT: t = (idx == last);
      ST_POST:  t = (idx == '0);
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  assign last_q = IW'(len_q) - IW'(1);
  assign last_d = IW'(len_d) - IW'(1);
  assign sh_amt = LW'(MAX_LEN) - cmd_len_i;

  // Rejection rules evaluated on the incoming command.
  always_comb begin
    cmd_err = 1'b0;
    if (cmd_len_i > LW'(MAX_LEN)) cmd_err = 1'b1;
    if ((cmd_len_i == '0) && (cmd_op_i != 2'd0)) cmd_err = 1'b1;
    if (cmd_op_i[1] && (tap_q == TAP_UNKNOWN)) cmd_err = 1'b1;
  end

  // Index of the last preamble tick for the latched op.
  always_comb begin
    case (op_q)
      OP_RESET: pre_last = IW'(5);
      OP_IDLE:  pre_last = last_q;
      OP_IR:    pre_last = IW'(3);
      default:  pre_last = IW'(2);
    endcase
  end

  // Next-state logic: command acceptance, TCK phase timing, segment stepping.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    sh_d       = sh_q;
    rsp_d      = rsp_q;
    err_d      = err_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    tap_d      = tap_q;
    start_tick = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d  = op_e'(cmd_op_i);
          len_d = cmd_len_i;
          rsp_d = '0;
          err_d = cmd_err;
          // Left-align the payload so the first bit to shift is the MSB.
          sh_d  = cmd_data_i << sh_amt;
          idx_d = '0;
          cnt_d = '0;
          tck_d = 1'b0;
          if (cmd_err) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_PRE;
            start_tick = 1'b1;
          end
        end
      end

      ST_PRE, ST_SHIFT, ST_POST: begin
        if (!tck_q) begin
          if (cnt_q == DIVC) begin
            tck_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q != DIVC) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Last clk of the high phase: sample TDO, fall TCK, begin next tick.
          tck_d      = 1'b0;
          cnt_d      = '0;
          start_tick = 1'b1;
          if (state_q == ST_SHIFT) rsp_d = {rsp_q[MAX_LEN-2:0], tdo_i};
          case (state_q)
            ST_PRE: begin
              if (idx_q == pre_last) begin
                idx_d = '0;
                if ((op_q == OP_RESET) || (op_q == OP_IDLE)) begin
                  state_d    = ST_RESP;
                  start_tick = 1'b0;
                  if (op_q == OP_RESET) tap_d = TAP_RTI;
                end else begin
                  state_d = ST_SHIFT;
                end
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
            ST_SHIFT: begin
              if (idx_q == last_q) begin
                idx_d   = '0;
                state_d = ST_POST;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
            default: begin
              if (idx_q == IW'(1)) begin
                idx_d      = '0;
                state_d    = ST_RESP;
                start_tick = 1'b0;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
          endcase
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // TMS/TDI change only at the start of a tick's low phase.
    if (start_tick) begin
      tms_d = tms_for(op_d, state_d, idx_d, last_d);
      if (state_d == ST_SHIFT) begin
        tdi_d = sh_d[MAX_LEN-1];
        sh_d  = {sh_d[MAX_LEN-2:0], 1'b0};
      end else begin
        tdi_d = 1'b0;
      end
    end else if ((state_d == ST_RESP) || (state_d == ST_IDLE)) begin
      tdi_d = 1'b0;
    end
  end

  // State registers; reset forces TCK low and forgets the TAP state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RESET;
      len_q   <= '0;
      sh_q    <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      tap_q   <= TAP_UNKNOWN;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      tap_q   <= tap_d;
    end
  end

`ifdef JTAG_HOST_TRST_EN
  logic trst_q, trst_d;

  // TRST is low for ticks 0 and 1 of a RESET op, updated with TMS.
  always_comb begin
    trst_d = trst_q;
    if (start_tick) begin
      trst_d = !((op_d == OP_RESET) && (state_d == ST_PRE) && (idx_d < IW'(2)));
    end else if ((state_d == ST_RESP) || (state_d == ST_IDLE)) begin
      trst_d = 1'b1;
    end
  end

  // TRST register, deasserted (high) out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trst_q <= 1'b1;
    else         trst_q <= trst_d;
  end

  assign trst_o = trst_q;
`endif

  assign cmd_ready_o     = (state_q == ST_IDLE);
  assign rsp_valid_o     = (state_q == ST_RESP);
  assign rsp_data_o      = rsp_q;
  assign rsp_err_o       = err_q;
  assign tck_o           = tck_q;
  assign tms_o           = tms_q;
  assign tdi_o           = tdi_q;
  assign dbg_state_o     = state_q;
  assign dbg_tap_known_o = (tap_q == TAP_RTI);

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed bench for jtag_host (DIV=1, MAX_LEN=64) against a
// behavioural 16-state TAP with IDCODE and a 32-bit DMI register. Expected
// responses are queued when a command is issued and compared on response.
module tb_jtag_host;

  localparam int MAX_LEN = 64;
  localparam logic [31:0] IDCODE    = 32'h1BEEF001;
  localparam logic [5:0]  IR_IDCODE = 6'b000001;
  localparam logic [5:0]  IR_DMI    = 6'b101010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_ready = 1'b0;
  logic        tdo = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, tck, tms, tdi;
  logic [63:0] rsp_data;
  logic [2:0]  dbg_state;
  logic        dbg_tap_known;
`ifdef JTAG_HOST_TRST_EN
  logic        trst;
`endif

  jtag_host #(.DIV(1), .MAX_LEN(MAX_LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo),
`ifdef JTAG_HOST_TRST_EN
    .trst_o(trst),
`endif
    .dbg_state_o(dbg_state), .dbg_tap_known_o(dbg_tap_known)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  tap_e        m_st = TLR;
  logic [5:0]  m_ir = IR_IDCODE;
  logic [5:0]  m_irs = '0;
  logic [31:0] m_dr = '0;
  logic [31:0] m_upd = '0;
  int          tck_cnt = 0;
  logic [15:0] tms_hist = '0;
  logic [15:0] trst_hist = '0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tck_cnt++;
    tms_hist = {tms_hist[14:0], tms};
`ifdef JTAG_HOST_TRST_EN
    trst_hist = {trst_hist[14:0], trst};
`endif
    case (m_st)
      TLR:   m_ir <= IR_IDCODE;
      CAPDR: m_dr <= (m_ir == IR_IDCODE) ? IDCODE : ((m_ir == IR_DMI) ? m_upd : 32'h0);
      SHDR:  m_dr <= {m_dr[30:0], tdi};
      UPDR:  if (m_ir == IR_DMI) m_upd <= m_dr;
      CAPIR: m_irs <= 6'b000001;
      SHIR:  m_irs <= {m_irs[4:0], tdi};
      UPIR:  m_ir <= m_irs;
      default: ;
    endcase
    m_st <= tap_next(m_st, tms);
  end

  // Target drives TDO on the falling edge, MSB of the selected shift register.
  always @(negedge tck) begin
    tdo <= (m_st == SHDR) ? m_dr[31] : ((m_st == SHIR) ? m_irs[5] : 1'b0);
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic        exp_err_q[$];
  int          checks = 0;
  int          errors = 0;
  time         acc_t = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a command and wait for its acceptance edge (called at a negedge).
  task automatic issue(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                       input logic [63:0] exp_data, input logic exp_err);
    int n;
    n = 0;
    exp_q.push_back(exp_data);
    exp_err_q.push_back(exp_err);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    check("accept_ready", cmd_ready, 1'b1);
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, compare against the queue head, then consume it.
  task automatic get_rsp(input string tag, input int exp_lat);
    int n;
    logic [63:0] e;
    logic ee;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_valid"}, rsp_valid, 1'b1);
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(($time - acc_t - 5) / 10), 64'(exp_lat));
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    ee = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'bx;
    check({tag, "_data"}, rsp_data, e);
    check({tag, "_err"}, rsp_err, ee);
    check({tag, "_tck_low"}, tck, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int n;
    logic seen_ready;
    logic [31:0] rnd;

    rnd = $urandom;
    repeat (3) @(negedge clk);
    check("rst_tck", tck, 1'b0);
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_tap_unknown", dbg_tap_known, 1'b0);
`ifdef JTAG_HOST_TRST_EN
    check("rst_trst", trst, 1'b1);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // rsp_ready with nothing pending is ignored
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stray_ready_valid", rsp_valid, 1'b0);
    check("stray_ready_cmd_ready", cmd_ready, 1'b1);

    // IR scan while TAP state unknown: rejected, no TCK
    t0 = tck_cnt;
    issue(2'd2, 7'd6, 64'h2A, 64'h0, 1'b1);
    check("ir_unknown_fast", rsp_valid, 1'b1);
    get_rsp("ir_unknown", 0);
    check("ir_unknown_ticks", 64'(tck_cnt - t0), 64'd0);

    // RESET: 6 ticks, TMS 111110, response held until rsp_ready
    t0 = tck_cnt;
    issue(2'd0, 7'd0, 64'h0, 64'h0, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("reset_held", rsp_valid, 1'b1);
    check("reset_ticks", 64'(tck_cnt - t0), 64'd6);
    check("reset_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
`ifdef JTAG_HOST_TRST_EN
    check("reset_trst_seq", 64'(trst_hist[5:0]), 64'(6'b001111));
`endif
    acc_t = acc_t + 50;  // five extra cycles were spent holding rsp_ready low
    get_rsp("reset", 24);
    check("reset_model_rti", m_st, RTI);
    check("reset_tap_known", dbg_tap_known, 1'b1);

    // Zero-length and over-length scans are rejected
    t0 = tck_cnt;
    issue(2'd3, 7'd0, 64'h0, 64'h0, 1'b1);
    check("dr_len0_fast", rsp_valid, 1'b1);
    get_rsp("dr_len0", 0);
    issue(2'd3, 7'(MAX_LEN + 1), {64{1'b1}}, 64'h0, 1'b1);
    check("dr_long_fast", rsp_valid, 1'b1);
    get_rsp("dr_long", 0);
    check("err_ticks", 64'(tck_cnt - t0), 64'd0);

    // IDCODE read: 37 ticks
    t0 = tck_cnt;
    issue(2'd3, 7'd32, 64'h0, {32'h0, IDCODE}, 1'b0);
    get_rsp("idcode", 148);
    check("idcode_ticks", 64'(tck_cnt - t0), 64'd37);
    check("idcode_model_rti", m_st, RTI);

    // Select DMI: capture pattern 000001 comes back
    t0 = tck_cnt;
    issue(2'd2, 7'd6, 64'(IR_DMI), 64'h01, 1'b0);
    get_rsp("ir_dmi", 48);
    check("ir_dmi_ticks", 64'(tck_cnt - t0), 64'd12);
    check("ir_dmi_model_ir", m_ir, IR_DMI);

    // DMI writes: first returns the reset value, second reads back DEADBEEF
    issue(2'd3, 7'd32, 64'hDEADBEEF, 64'h0, 1'b0);
    get_rsp("dmi_wr1", 148);
    check("dmi_wr1_upd", m_upd, 32'hDEADBEEF);
    issue(2'd3, 7'd32, {32'h0, rnd}, 64'hDEADBEEF, 1'b0);
    get_rsp("dmi_wr2", 148);
    check("dmi_wr2_upd", m_upd, rnd);

    // IDLE clocks: TMS low throughout
    t0 = tck_cnt;
    issue(2'd1, 7'd5, 64'h0, 64'h0, 1'b0);
    get_rsp("idle5", 20);
    check("idle5_ticks", 64'(tck_cnt - t0), 64'd5);
    check("idle5_tms", 64'(tms_hist[4:0]), 64'h0);
    check("idle5_model_rti", m_st, RTI);

    // Backpressure: response held 20 clk while the next command waits
    t0 = tck_cnt;
    issue(2'd0, 7'd0, 64'h0, 64'h0, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    cmd_op = 2'd1; cmd_len = 7'd3; cmd_data = 64'h0; cmd_valid = 1'b1;
    exp_q.push_back(64'h0);
    exp_err_q.push_back(1'b0);
    seen_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0) seen_ready = 1'b1;
    end
    check("hold_cmd_ready_low", seen_ready, 1'b0);
    check("hold_rsp_valid", rsp_valid, 1'b1);
    check("hold_state_resp", dbg_state, 3'd4);
    check("hold_ticks", 64'(tck_cnt - t0), 64'd6);
    get_rsp("hold_reset", -1);
    check("hold_next_ready", cmd_ready, 1'b1);
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    cmd_valid = 1'b0;
    t0 = tck_cnt;
    get_rsp("hold_idle", 12);
    check("hold_idle_ticks", 64'(tck_cnt - t0), 64'd3);

    // Reset during shift tick 9 of a 32-bit DR scan
    t0 = tck_cnt;
    issue(2'd3, 7'd32, 64'h12345678, 64'h0, 1'b0);
    n = 0;
    while ((tck_cnt - t0) < 13 && n < 2000) begin @(negedge clk); n++; end
    check("midrst_model_shift", m_st, SHDR);
    check("midrst_tck_high", tck, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_tck", tck, 1'b0);
    check("midrst_tms", tms, 1'b1);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_tap_unknown", dbg_tap_known, 1'b0);
    exp_q.delete();
    exp_err_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    t0 = tck_cnt;
    issue(2'd3, 7'd32, 64'h0, 64'h0, 1'b1);
    check("post_rst_dr_fast", rsp_valid, 1'b1);
    get_rsp("post_rst_dr", 0);
    check("post_rst_dr_ticks", 64'(tck_cnt - t0), 64'd0);

    t0 = tck_cnt;
    issue(2'd0, 7'd0, 64'h0, 64'h0, 1'b0);
    get_rsp("recover_reset", 24);
    check("recover_ticks", 64'(tck_cnt - t0), 64'd6);
    check("recover_model_rti", m_st, RTI);
    issue(2'd3, 7'd32, 64'h0, {32'h0, IDCODE}, 1'b0);
    get_rsp("recover_idcode", 148);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
